prng_collector: RTL and testbench
=================================

# prng_collector

Receiving end of the PRNG serial output stream. Accepts one random bit per handshake from the bit-serial generator, packs bits MSB-first into WORD_W-bit words, and buffers completed words in a small FIFO presented to downstream logic over a valid/ready interface. Its `bit_rdy` output is the generator's step enable, so backpressure stalls the generator without losing bits.

## Interface
- `WORD_W`, 8: packed word width; legal range 2–32.
- `DEPTH`, 4: FIFO depth in words; power of two, 2–16.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rstn`  input  1  asynchronous active-low reset.
- `bit_vld`  input  1  generator presents a valid bit.
- `bit_in`  input  1  random bit; sampled when `bit_vld && bit_rdy`.
- `bit_rdy`  output  1  collector accepts a bit this cycle; drives the generator's step enable.
- `word_vld`  output  1  FIFO head word is valid.
- `word`  output  WORD_W  FIFO head word.
- `word_rdy`  input  1  consumer takes the head word when `word_vld && word_rdy`.
- `fill`  output  $clog2(DEPTH)+1  number of words in the FIFO.
- `stuck`  output  1  sticky repeat-detect flag; present only with `PRNG_COLLECT_CHECK_EN`.

## Operation
- Packer: shift register `sr` [WORD_W-1:0] plus bit counter `bcnt` (0..WORD_W-1, wraps to 0).
- Bit accept (`bit_vld && bit_rdy`): `sr <= {sr[WORD_W-2:0], bit_in}`; `bcnt <= bcnt+1`.
- On the accept where `bcnt == WORD_W-1`: push `{sr[WORD_W-2:0], bit_in}` into the FIFO at `wr_ptr`; `bcnt <= 0`. The first bit received for a word lands in the word's MSB.
- `bit_rdy = (fill != DEPTH)`, decoded from registered state only. A push therefore never meets a full FIFO, and there is no overflow path.
- FIFO: `DEPTH` entries, `wr_ptr`/`rd_ptr` of width $clog2(DEPTH) wrapping modulo DEPTH, `fill` counter.
- `word = mem[rd_ptr]`; `word_vld = (fill != 0)`.
- Pop on `word_vld && word_rdy`: `rd_ptr <= rd_ptr+1`.
- Simultaneous push and pop: `fill` is unchanged and both pointers advance.
- `word_rdy` asserted while `word_vld` is 0 has no effect. `bit_vld` low holds the packer unchanged; partial words are retained indefinitely.
- Reset (async, any time, including mid-word):
  - `sr=0`, `bcnt=0`, pointers 0, `fill=0`.
  - Outputs: `word_vld=0`, `word=mem[0]` (mem is not reset, so `word` is don't-care while `word_vld=0`), `bit_rdy=1`, `stuck=0`.
  - Partially packed bits are discarded.

## Timing
- `bit_rdy` and `word_vld` depend only on registered state; there are no combinational paths from `bit_vld` or `word_rdy` to any output.
- Latency: a word completed at edge N (last bit accepted) gives `word_vld=1` and valid `word` in the cycle after edge N.
- Throughput: 1 bit per clock sustained while `fill < DEPTH`. When the FIFO is full, `bit_rdy` drops the cycle after the filling push and rises the cycle after the first pop.
- Full-rate example, WORD_W=8: a word every 8 clocks.

## Configuration
- `PRNG_COLLECT_CHECK_EN` defined:
  - Compares each pushed word with the previously pushed word.
  - A 2-bit saturating repeat counter increments on an equal push and clears on an unequal push.
  - `stuck` sets when 4 consecutive pushed words are identical (3 equal comparisons) and stays set until reset.
  - The first pushed word after reset has no predecessor and is never counted as a repeat.
- Not defined: the `stuck` port, comparator and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then drive bits 1,0,1,1,0,0,1,0 with `bit_vld=1` and `word_rdy=1` -> one cycle after the 8th accept, `word_vld=1` and `word=8'hB2`; `fill` returns to 0 after the pop.
- Hold `word_rdy=0` and stream 40 bits -> `fill` reaches 4 and `bit_rdy=0` after the 32nd bit; `bit_in` is ignored. Assert `word_rdy` for one cycle -> `fill=3` and `bit_rdy=1` on the next cycle; no bits are lost or duplicated.
- Continuous stream with `word_rdy` toggling every cycle -> output words match a reference packer model exactly, including cycles with simultaneous push and pop.
- Assert `rstn` low after 5 bits of a word -> all outputs are at reset values immediately (asynchronously). The next 8 bits after reset form a fresh word with no residue from the aborted one.
- Idle `bit_vld` mid-word for 20 cycles -> `bcnt` is held; the word completes correctly when bits resume.
- With `PRNG_COLLECT_CHECK_EN`: push 8'hFF four times -> `stuck=1` after the 4th push and remains 1 through further unequal words. Push FF,FF,FF,00,FF -> `stuck` stays 0.

Source files
------------

// File: rtl/prng_collector.sv
// -----------------------------------------------------------------------------
// prng_collector
//
// Receiving end of a bit-serial PRNG stream. Bits arrive one per handshake,
// are packed MSB-first into WORD_W-bit words, and completed words are queued
// in a DEPTH-entry FIFO offered downstream over valid/ready. bit_rdy doubles
// as the generator's step enable, so a full FIFO stalls the generator
// instead of dropping bits.
//
// Optional feature macro: PRNG_COLLECT_CHECK_EN
//   When defined, adds a repeat detector and the sticky `stuck` output, which
//   sets once four consecutive pushed words are identical.
//
// Parameters
//   WORD_W  packed word width, 2..32
//   DEPTH   FIFO depth in words, power of two, 2..16
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   bit_vld   generator presents a bit
//   bit_in    the bit, taken when bit_vld && bit_rdy
//   bit_rdy   collector can take a bit this cycle (generator step enable)
//   word_vld  FIFO head is valid
//   word      FIFO head word
//   word_rdy  consumer takes the head word when word_vld && word_rdy
//   fill      number of words currently held in the FIFO
//   stuck     sticky repeat flag (PRNG_COLLECT_CHECK_EN only)
// -----------------------------------------------------------------------------
module prng_collector #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   bit_vld,
  input  logic                   bit_in,
  output logic                   bit_rdy,
  output logic                   word_vld,
  output logic [WORD_W-1:0]      word,
  input  logic                   word_rdy,
  output logic [$clog2(DEPTH):0] fill
`ifdef PRNG_COLLECT_CHECK_EN
  ,
  output logic                   stuck
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WORD_W);

  localparam logic [BW-1:0] BCNT_LAST = BW'(WORD_W - 1);
  localparam logic [AW:0]   FILL_FULL = (AW + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  // Only the low WORD_W-1 bits of the shift register are kept: the oldest bit
  // of a full-width register would be shifted out on the very accept that
  // completes the word, so it is never observed.
  logic [WORD_W-2:0] sr;
  logic [BW-1:0]     bcnt;
  logic [WORD_W-1:0] next_word;
  logic              bit_acc;
  logic              push;
  logic              pop;

  assign bit_acc   = bit_vld && bit_rdy;
  assign next_word = {sr, bit_in};
  assign push      = bit_acc && (bcnt == BCNT_LAST);
  assign pop       = word_vld && word_rdy;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (bit_acc) begin
      sr   <= next_word[WORD_W-2:0];
      bcnt <= push ? '0 : bcnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       fill_nxt;

  // NOTE: the storage array has no reset; its contents are only observed
  // while word_vld is high, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= next_word;
    end
  end

  // NOTE: the default is assigned first so every path through the block
  // drives fill_nxt and no latch is inferred.
  always_comb begin
    fill_nxt = fill;
    unique case ({push, pop})
      2'b10:   fill_nxt = fill + 1'b1;
      2'b01:   fill_nxt = fill - 1'b1;
      default: fill_nxt = fill;
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH
  // on their own.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fill <= fill_nxt;
    end
  end

  // Handshake outputs come from the registered fill count only. Because
  // bit_rdy is low whenever the FIFO is full, a push can never overflow.
  assign bit_rdy  = (fill != FILL_FULL);
  assign word_vld = (fill != '0);
  assign word     = mem[rd_ptr];

`ifdef PRNG_COLLECT_CHECK_EN
  // ---------------------------------------------------------------------------
  // Repeat detector
  // ---------------------------------------------------------------------------
  // rep_cnt counts consecutive equal comparisons (saturating at 3). The first
  // word after reset has no predecessor, which have_prev guards.
  logic [WORD_W-1:0] prev_word;
  logic              have_prev;
  logic [1:0]        rep_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      rep_cnt   <= '0;
      stuck     <= 1'b0;
    end else if (push) begin
      prev_word <= next_word;
      have_prev <= 1'b1;
      if (have_prev && (next_word == prev_word)) begin
        if (rep_cnt != 2'd3) begin
          rep_cnt <= rep_cnt + 1'b1;
        end
        // Third equal comparison in a row means four identical words.
        if (rep_cnt == 2'd2) begin
          stuck <= 1'b1;
        end
      end else begin
        rep_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prng_collector.sv
// -----------------------------------------------------------------------------
// tb_prng_collector
//
// Self-checking bench for prng_collector (WORD_W=8, DEPTH=4). A queue-based
// model of the collector is updated on every rising edge; a compare process
// checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations at the interesting points.
// Define PRNG_COLLECT_CHECK_EN to include the repeat-detector scenarios.
// -----------------------------------------------------------------------------
module tb_prng_collector;

  localparam int WORD_W = 8;
  localparam int DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   bit_vld = 1'b0;
  logic                   bit_in = 1'b0;
  logic                   bit_rdy;
  logic                   word_vld;
  logic [WORD_W-1:0]      word;
  logic                   word_rdy = 1'b0;
  logic [$clog2(DEPTH):0] fill;
`ifdef PRNG_COLLECT_CHECK_EN
  logic                   stuck;
`endif

  int errors = 0;
  int checks = 0;

  prng_collector #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bit_vld  (bit_vld),
    .bit_in   (bit_in),
    .bit_rdy  (bit_rdy),
    .word_vld (word_vld),
    .word     (word),
    .word_rdy (word_rdy),
    .fill     (fill)
`ifdef PRNG_COLLECT_CHECK_EN
    ,
    .stuck    (stuck)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: bits accumulate arithmetically into a partial word; a
  // completed word goes to the back of a queue, the head is popped when the
  // consumer is ready. Acceptance depends only on the queue length seen
  // before the edge.
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] mq[$];
  logic [WORD_W-1:0] hist[$];
  int unsigned       pword = 0;
  int                pbits = 0;
  bit                stuck_m = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        mq.delete();
        hist.delete();
        pword   = 0;
        pbits   = 0;
        stuck_m = 1'b0;
      end else begin
        bit can_take;
        can_take = (mq.size() < DEPTH);
        if (mq.size() > 0 && word_rdy) begin
          void'(mq.pop_front());
        end
        if (bit_vld && can_take) begin
          pword = pword * 2 + (bit_in ? 1 : 0);
          pbits++;
          if (pbits == WORD_W) begin
            mq.push_back(WORD_W'(pword));
            hist.push_back(WORD_W'(pword));
            if (hist.size() > 4) begin
              void'(hist.pop_front());
            end
            if (hist.size() == 4 && hist[0] == hist[1] && hist[1] == hist[2]
                && hist[2] == hist[3]) begin
              stuck_m = 1'b1;
            end
            pword = 0;
            pbits = 0;
          end
        end
      end
    end
  end

  // Compare process: outputs are registered, so the falling edge is a quiet
  // point between updates.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        check("cmp_fill", 32'(fill), 32'(mq.size()));
        check("cmp_word_vld", 32'(word_vld), 32'(mq.size() != 0));
        check("cmp_bit_rdy", 32'(bit_rdy), 32'(mq.size() != DEPTH));
        if (mq.size() != 0) begin
          check("cmp_word", 32'(word), 32'(mq[0]));
        end
`ifdef PRNG_COLLECT_CHECK_EN
        check("cmp_stuck", 32'(stuck), 32'(stuck_m));
`endif
      end
    end
  end

  // Inputs are applied 1 time unit after a rising edge and held for one cycle.
  task automatic step(input logic bv, input logic b, input logic wr);
    bit_vld  = bv;
    bit_in   = b;
    word_rdy = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WORD_W-1:0] w, input logic wr);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      step(1'b1, w[i], wr);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic [7:0] pat;

    // Reset values.
    do_reset();
    check("rst_bit_rdy", 32'(bit_rdy), 32'd1);
    check("rst_word_vld", 32'(word_vld), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
`ifdef PRNG_COLLECT_CHECK_EN
    check("rst_stuck", 32'(stuck), 32'd0);
`endif

    // First word: 1,0,1,1,0,0,1,0 -> 8'hB2, visible the cycle after the 8th accept.
    pat = 8'hB2;
    push_word(pat, 1'b1);
    check("b2_word_vld", 32'(word_vld), 32'd1);
    check("b2_word", 32'(word), 32'hB2);
    step(1'b0, 1'b0, 1'b1);
    check("b2_fill_after_pop", 32'(fill), 32'd0);

    // Backpressure: 40 bits with the consumer stalled fills the FIFO after 32.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("full_fill", 32'(fill), 32'd4);
    check("full_bit_rdy", 32'(bit_rdy), 32'd0);
    step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    check("pop1_fill", 32'(fill), 32'd3);
    check("pop1_bit_rdy", 32'(bit_rdy), 32'd1);
    drain();

    // Full-rate stream with word_rdy toggling every cycle.
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'(i % 2));
    end

    // Randomised bit_vld / word_rdy.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    drain();

    // Asynchronous reset mid-word with a word waiting in the FIFO.
    do_reset();
    push_word(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("pre_rst_fill", 32'(fill), 32'd1);
    rstn = 1'b0;
    #1;
    check("async_rst_word_vld", 32'(word_vld), 32'd0);
    check("async_rst_fill", 32'(fill), 32'd0);
    check("async_rst_bit_rdy", 32'(bit_rdy), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    push_word(8'h5C, 1'b0);
    check("post_rst_word", 32'(word), 32'h5C);
    check("post_rst_fill", 32'(fill), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // Idle mid-word: 3 bits of A7, 20 idle cycles, remaining 5 bits.
    pat = 8'hA7;
    for (int i = 7; i >= 5; i--) begin
      step(1'b1, pat[i], 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("idle_fill", 32'(fill), 32'd0);
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, pat[i], 1'b0);
    end
    check("idle_word_vld", 32'(word_vld), 32'd1);
    check("idle_word", 32'(word), 32'hA7);
    drain();

`ifdef PRNG_COLLECT_CHECK_EN
    // Four identical words set stuck, and it stays set.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_word(8'hFF, 1'b1);
    end
    check("stuck_after3", 32'(stuck), 32'd0);
    push_word(8'hFF, 1'b1);
    check("stuck_after4", 32'(stuck), 32'd1);
    push_word(8'h00, 1'b1);
    push_word(8'hA5, 1'b1);
    check("stuck_sticky", 32'(stuck), 32'd1);
    drain();

    // An unequal word breaks the run.
    do_reset();
    push_word(8'hFF, 1'b1);
    push_word(8'hFF, 1'b1);
    push_word(8'hFF, 1'b1);
    push_word(8'h00, 1'b1);
    push_word(8'hFF, 1'b1);
    check("stuck_broken_run", 32'(stuck), 32'd0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
